// File: rtl/program_loader_if.sv
// Byte-stream, instruction-memory write and status bundle for the program loader.
interface program_loader_if;
  localparam int unsigned WIDTH    = 16;
  localparam int unsigned I_ADDR_W = 7;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned STATE_W  = 3;

  logic                start;
  logic [BYTE_W-1:0]   byte_in;
  logic                byte_valid;
  logic                byte_ready;
  logic                im_wr_en;
  logic [I_ADDR_W-1:0] im_wr_addr;
  logic [WIDTH-1:0]    im_wr_data;
  logic                cpu_hold;
  logic                done;
  logic                error;
  logic [CNT_W-1:0]    words_loaded;
  logic [STATE_W-1:0]  state_out;

  // Host / stream source side
  modport master (
    output start, byte_in, byte_valid,
    input  byte_ready, im_wr_en, im_wr_addr, im_wr_data,
           cpu_hold, done, error, words_loaded, state_out
  );

  // Loader side
  modport slave (
    input  start, byte_in, byte_valid,
    output byte_ready, im_wr_en, im_wr_addr, im_wr_data,
           cpu_hold, done, error, words_loaded, state_out
  );
endinterface

// File: rtl/program_loader.sv
// Boot loader: assembles a byte stream into 16-bit words, writes them to
// instruction memory, verifies an XOR checksum and releases the processor.
module program_loader (
  input  logic           clk,
  input  logic           rst_n,
  program_loader_if.slave lif
);
  localparam int unsigned WIDTH    = 16;
  localparam int unsigned I_ADDR_W = 7;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned CNT_W    = 8;
  localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(128);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    HI    = 3'd2,
    LO    = 3'd3,
    WRITE = 3'd4,
    CHECK = 3'd5,
    RUN   = 3'd6,
    ERR   = 3'd7
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    count_q;
  logic [I_ADDR_W-1:0] index_q;
  logic [I_ADDR_W-1:0] wr_addr_q;
  logic [BYTE_W-1:0]   hi_q, lo_q, csum_q;
  logic [CNT_W-1:0]    words_q;
  logic                ready_q, wr_en_q, hold_q, done_q, error_q;
  logic                ready_d, wr_en_d, hold_d, done_d, error_d;
  logic                xfer_c;
  logic                last_word_c;

  assign xfer_c      = lif.byte_valid & ready_q;
  assign last_word_c = (CNT_W'(index_q) == (count_q - CNT_W'(1)));

  // Next-state logic and Moore decode of the upcoming state
  always_comb begin
    state_d = state_q;
    ready_d = 1'b0;
    wr_en_d = 1'b0;
    hold_d  = 1'b1;
    done_d  = 1'b0;
    error_d = 1'b0;
    case (state_q)
      IDLE:  if (lif.start) state_d = COUNT;
      COUNT: if (xfer_c) begin
               if ((lif.byte_in == '0) || (lif.byte_in > MAX_WORDS)) state_d = ERR;
               else                                                  state_d = HI;
             end
      HI:    if (xfer_c) state_d = LO;
      LO:    if (xfer_c) state_d = WRITE;
      WRITE: state_d = last_word_c ? CHECK : HI;
      CHECK: if (xfer_c) state_d = (lif.byte_in == csum_q) ? RUN : ERR;
      RUN:   if (lif.start) state_d = COUNT;
      ERR:   if (lif.start) state_d = COUNT;
      default: state_d = IDLE;
    endcase
    case (state_d)
      COUNT, HI, LO, CHECK: ready_d = 1'b1;
      WRITE:                wr_en_d = 1'b1;
      RUN: begin
        hold_d = 1'b0;
        done_d = 1'b1;
      end
      ERR:                  error_d = 1'b1;
      default: ;
    endcase
  end

  // State and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      wr_en_q <= 1'b0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      wr_en_q <= wr_en_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  // Word assembly, checksum, write address and progress counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      index_q   <= '0;
      wr_addr_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      csum_q    <= '0;
      words_q   <= '0;
    end else begin
      if (state_q == COUNT && xfer_c) begin
        count_q <= lif.byte_in;
        index_q <= '0;
        csum_q  <= '0;
      end
      if (state_q == HI && xfer_c) begin
        hi_q   <= lif.byte_in;
        csum_q <= csum_q ^ lif.byte_in;
      end
      if (state_q == LO && xfer_c) begin
        lo_q      <= lif.byte_in;
        csum_q    <= csum_q ^ lif.byte_in;
        wr_addr_q <= index_q;
      end
      if (state_q == WRITE) begin
        index_q <= index_q + I_ADDR_W'(1);
        words_q <= words_q + CNT_W'(1);
      end
      if (state_d == COUNT && state_q != COUNT) words_q <= '0;
    end
  end

  assign lif.byte_ready   = ready_q;
  assign lif.im_wr_en     = wr_en_q;
  assign lif.im_wr_addr   = wr_addr_q;
  assign lif.im_wr_data   = WIDTH'({hi_q, lo_q});
  assign lif.cpu_hold     = hold_q;
  assign lif.done         = done_q;
  assign lif.error        = error_q;
  assign lif.words_loaded = words_q;
  assign lif.state_out    = state_q;
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time stage that sits directly upstream of the processor's instruction memory.
- Accepts a byte stream over a valid/ready handshake and assembles 16-bit instruction words, high byte first.
- Writes each word into instruction memory at consecutive 7-bit addresses starting at 0, then verifies an XOR checksum.
- Holds the processor in reset until a load completes cleanly, then releases it.

Parameters:
- WIDTH, 16, instruction word width.
- I_ADDR_W, 7, instruction memory address width (128 words).
- BYTE_W, 8, stream byte width; WIDTH = 2*BYTE_W.

Ports:
- Clk  input  1  processor clock, shared with the processor.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  single-cycle load request.
- Byte_In  input  8  stream data.
- Byte_Valid  input  1  Byte_In is valid.
- Byte_Ready  output  1  loader accepts Byte_In this cycle.
- IM_Wr_En  output  1  instruction memory write strobe.
- IM_Wr_Addr  output  7  instruction memory write address.
- IM_Wr_Data  output  16  instruction word to write.
- CPU_Hold  output  1  high holds the processor in reset.
- Done  output  1  load finished, checksum matched.
- Error  output  1  load aborted.
- Words_Loaded  output  8  count of words written in the current load (0..128).
- State_Out  output  3  FSM state, for debug.

Behaviour:
- Transfer rule: a byte transfers only when Byte_Valid and Byte_Ready are both high at a rising Clk. With Byte_Valid low the loader holds all state.
- Output decode: Byte_Ready, IM_Wr_En, CPU_Hold, Done and Error are Moore decodes of the state register.
- Reset (Reset=0, asynchronous):
  - state IDLE; word index, Words_Loaded, checksum, hi/lo/count registers all 0.
  - CPU_Hold=1; every other output 0.
- Reset mid-load: returns to IDLE. Memory words already written are not cleared.
- State encodings: IDLE=0, COUNT=1, HI=2, LO=3, WRITE=4, CHECK=5, RUN=6, ERR=7.
- IDLE: Byte_Ready=0, CPU_Hold=1. Start -> COUNT.
- COUNT: Byte_Ready=1. On transfer, capture N=Byte_In.
  - N==0 or N>128 -> ERR.
  - Otherwise clear index and checksum -> HI.
- HI: Byte_Ready=1. On transfer, hi=Byte_In, checksum^=Byte_In -> LO.
- LO: Byte_Ready=1. On transfer, lo=Byte_In, checksum^=Byte_In -> WRITE.
- WRITE: Byte_Ready=0, IM_Wr_En=1 for exactly one cycle, IM_Wr_Addr=index, IM_Wr_Data={hi,lo}.
  - On exit: index+1, Words_Loaded+1.
  - If index==N-1 -> CHECK, else -> HI.
- Minimum 3 cycles per word.
- CHECK: Byte_Ready=1. On transfer, Byte_In==checksum -> RUN, else -> ERR.
  - The checksum covers data bytes only; the count byte is excluded.
- RUN: CPU_Hold=0, Done=1, Byte_Ready=0.
- ERR: CPU_Hold=1, Error=1, Byte_Ready=0.
- Reload: Start in RUN or ERR -> COUNT. Done/Error drop and CPU_Hold rises on the next cycle. Words_Loaded clears on entry to COUNT.
- Start in COUNT/HI/LO/WRITE/CHECK is ignored.
- Address range: index never exceeds N-1 ≤ 127, so IM_Wr_Addr does not wrap.
- Outside WRITE, IM_Wr_Addr and IM_Wr_Data hold their last values; they are don't-care while IM_Wr_En=0.

Test Plan:
- Normal load: Start; bytes 0x02,0x12,0x34,0xAB,0xCD,0x40 with Byte_Valid held high -> writes addr0=0x1234, addr1=0xABCD; Words_Loaded=2; Done=1, CPU_Hold=0, State_Out=6.
- Bad checksum: same stream with final byte 0x41 -> both writes occur; then Error=1, CPU_Hold=1, Done=0, Byte_Ready=0, State_Out=7.
- Illegal count: count byte 0x00 -> ERR, no IM_Wr_En pulse. Repeat with 0x81 -> ERR, no IM_Wr_En pulse.
- Backpressure: insert 1-3 cycle Byte_Valid gaps between every byte of the normal load -> identical writes and result. Byte_Ready=0 in every WRITE cycle; no byte is lost or duplicated.
- Full memory: N=0x80 (128), 256 data bytes of 0x00, checksum 0x00 -> last write to addr 127; Words_Loaded=128; Done=1.
- Reset mid-load: drive Reset=0 in HI after one word is written -> immediately IDLE, CPU_Hold=1, Words_Loaded=0. After release, Start plus the normal-load stream -> Done=1.
